// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Round-robin arbiter that gives four requesters write access to
//            one shared N-bit register. It selects one winner per clock edge
//            and writes the winner's data with a latency of one edge.
//            Optional owner-lock feature: define REG_WRITE_ARBITER_LOCK_EN to
//            add the 'lock' input.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
  parameter  int N         = 32,
  localparam int REQ_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REQ_COUNT-1:0]   req,
  input  logic [REQ_COUNT*N-1:0] data_i,
`ifdef REG_WRITE_ARBITER_LOCK_EN
  input  logic                   lock,
`endif
  output logic [REQ_COUNT-1:0]   grant,
  output logic [N-1:0]           q,
  output logic                   q_valid,
  output logic [1:0]             owner
);

  logic [1:0]           ptr_q,     ptr_d;
  logic [N-1:0]         q_q,       q_d;
  logic [REQ_COUNT-1:0] grant_q,   grant_d;
  logic                 q_valid_q, q_valid_d;
  logic [1:0]           owner_q,   owner_d;

  logic [1:0]           w_rr_winner;
  logic [1:0]           w_winner;
  logic                 w_locked;

  // Round-robin search: the first requester at or above ptr, modulo 4.
  always_comb begin
    w_rr_winner = ptr_q;
    for (int k = REQ_COUNT - 1; k >= 0; k--) begin
      // Walk the offsets backwards so that the lowest offset is written last and wins.
      if (req[ptr_q + 2'(k)]) begin
        w_rr_winner = ptr_q + 2'(k);
      end
    end
  end

  // The owner lock takes priority over round-robin while the owner keeps requesting.
`ifdef REG_WRITE_ARBITER_LOCK_EN
  assign w_locked = lock & req[owner_q];
`else
  assign w_locked = 1'b0;
`endif

  assign w_winner = w_locked ? owner_q : w_rr_winner;

  // Next-state computation: write the winner's data, or hold and clear the strobes.
  always_comb begin
    ptr_d     = ptr_q;
    q_d       = q_q;
    owner_d   = owner_q;
    grant_d   = '0;
    q_valid_d = 1'b0;
    if (req != '0) begin
      q_d       = data_i[int'(w_winner)*N +: N];
      owner_d   = w_winner;
      q_valid_d = 1'b1;
      grant_d   = REQ_COUNT'(1) << w_winner;
      // A locked write leaves the rotation where it was.
      if (!w_locked) begin
        ptr_d = w_winner + 2'd1;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q     <= '0;
      q_q       <= '0;
      grant_q   <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      q_q       <= q_d;
      grant_q   <= grant_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
    end
  end

  assign grant   = grant_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign owner   = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Brief    : Self-checking scoreboard bench for reg_write_arbiter (N=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

  localparam int N = 32;

  typedef struct packed {
    logic [3:0]   g;
    logic [N-1:0] d;
    logic         v;
    logic [1:0]   o;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [3:0]     req = '0;
  logic [4*N-1:0] data_i;
  logic           lock_s = 1'b0;
  logic [3:0]     grant;
  logic [N-1:0]   q;
  logic           q_valid;
  logic [1:0]     owner;

  logic [N-1:0]   data_a [4];

  // Reference model state.
  int             m_ptr = 0;
  logic [N-1:0]   m_q = '0;
  int             m_owner = 0;

  exp_t           sb [$];
  int             n_tests = 0;
  int             n_fail = 0;

  assign data_i = {data_a[3], data_a[2], data_a[1], data_a[0]};

  reg_write_arbiter #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data_i  (data_i),
`ifdef REG_WRITE_ARBITER_LOCK_EN
    .lock    (lock_s),
`endif
    .grant   (grant),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one edge worth of stimulus, predict the result, then compare it.
  task automatic step(input logic r, input logic [3:0] rq, input logic l);
    exp_t       e;
    exp_t       got;
    int         w;
    logic [3:0] one;
    @(negedge clk);
    reset  = r;
    req    = rq;
    lock_s = l;
    one    = 4'b0001;
    if (!r) begin
      m_ptr = 0; m_q = '0; m_owner = 0;
      e.g = '0; e.d = '0; e.v = 1'b0; e.o = '0;
    end else if (rq == 4'b0000) begin
      e.g = '0; e.d = m_q; e.v = 1'b0; e.o = 2'(m_owner);
    end else begin
`ifdef REG_WRITE_ARBITER_LOCK_EN
      if (l && rq[m_owner]) begin
        w = m_owner;
      end else
`endif
      begin
        w = m_ptr;
        while (!rq[w]) w = (w + 1) % 4;
        m_ptr = (w + 1) % 4;
      end
      m_q = data_a[w];
      m_owner = w;
      e.g = one << w; e.d = m_q; e.v = 1'b1; e.o = 2'(w);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("grant",   64'(grant),   64'(got.g));
    check("q",       64'(q),       64'(got.d));
    check("q_valid", 64'(q_valid), 64'(got.v));
    check("owner",   64'(owner),   64'(got.o));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) data_a[i] = 32'h1111_1111 * (i + 1);

    // Reset held with all requests active.
    step(1'b0, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b0);

    // Single request, then idle.
    data_a[2] = 32'hDEADBEEF;
    step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b0000, 1'b0);

    // Full rotation from a fresh reset.
    data_a[2] = 32'h3333_3333;
    step(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b1111, 1'b0);

    // Wrap to 3, then skip the idle requesters.
    step(1'b1, 4'b1000, 1'b0);
    step(1'b1, 4'b0101, 1'b0);
    step(1'b1, 4'b0101, 1'b0);

    // A single requester that stays active wins on every edge.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0010, 1'b0);

    // Reset arriving in the middle of activity.
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);

`ifdef REG_WRITE_ARBITER_LOCK_EN
    // Lock onto requester 1, then release it.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b0);
`endif

    // Random traffic with random data and occasional resets.
    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < 4; j++) data_a[j] = $urandom;
      step(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
